// File: rtl/cpu_mem_ctrl.sv
// rtl/cpu_mem_ctrl.sv - program loader, instruction fetch and CPU load/store port over one 32-bit memory
module cpu_mem_ctrl #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          halt_req,
  input  logic          prog_valid,
  input  logic [31:0]   prog_data,
  input  logic          prog_last,
  output logic          prog_ready,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_address,
  input  logic          write_mem,
  input  logic [AW-1:0] mem_wadrs,
  input  logic [31:0]   mem_wdata,
  input  logic          read_mem_str,
  input  logic [AW-1:0] mem_radrs_ld,
  output logic [31:0]   instruction_fetch,
  output logic [31:0]   mem_store_data,
  output logic          fetch_enabled,
  output logic [AW-1:0] pc_cnt,
  output logic [AW:0]   load_count
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pointer;
  logic [31:0]   mem [DEPTH];

  logic          cpu_active;
  logic          load_we;
  logic          cpu_we;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;

  assign cpu_active = (state == RUN) || (state == HALT);
  assign load_we    = (state == LOAD) && prog_valid;
  assign cpu_we     = cpu_active && write_mem;
  // Loader and CPU stores are mutually exclusive by state, so they share one write port.
  assign mem_we     = resetn && (load_we || cpu_we);
  assign wr_addr    = load_we ? pointer : mem_wadrs;
  assign wr_data    = load_we ? prog_data : mem_wdata;
  assign rd_word    = mem[mem_radrs_ld];

  assign instruction_fetch = fetch_enabled ? mem[pc_cnt] : 32'h0;

  // Memory contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      pc_cnt         <= '0;
      pointer        <= '0;
      load_count     <= '0;
      mem_store_data <= '0;
      prog_ready     <= 1'b0;
      fetch_enabled  <= 1'b0;
    end else begin
      // Write-first: a same-cycle store to the load address forwards the new data.
      if (cpu_active && read_mem_str)
        mem_store_data <= (cpu_we && (mem_wadrs == mem_radrs_ld)) ? mem_wdata : rd_word;

      case (state)
        IDLE, HALT: begin
          if (start) begin
            state         <= LOAD;
            pointer       <= '0;
            load_count    <= '0;
            prog_ready    <= 1'b1;
            fetch_enabled <= 1'b0;
          end
        end
        LOAD: begin
          if (prog_valid) begin
            load_count <= load_count + {{AW{1'b0}}, 1'b1};
            // Pointer stops at the top word instead of wrapping.
            if (prog_last || (pointer == '1)) begin
              state         <= RUN;
              pc_cnt        <= '0;
              prog_ready    <= 1'b0;
              fetch_enabled <= 1'b1;
            end else begin
              pointer <= pointer + {{(AW-1){1'b0}}, 1'b1};
            end
          end
        end
        RUN: begin
          if (halt_req) begin
            state         <= HALT;
            fetch_enabled <= 1'b0;
          end else if (branch_valid) begin
            pc_cnt <= branch_address;
          end else begin
            pc_cnt <= pc_cnt + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb/tb_cpu_mem_ctrl.sv - directed self-checking bench for cpu_mem_ctrl
module tb_cpu_mem_ctrl;

  localparam int AW    = 11;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic          halt_req;
  logic          prog_valid;
  logic [31:0]   prog_data;
  logic          prog_last;
  logic          prog_ready;
  logic          branch_valid;
  logic [AW-1:0] branch_address;
  logic          write_mem;
  logic [AW-1:0] mem_wadrs;
  logic [31:0]   mem_wdata;
  logic          read_mem_str;
  logic [AW-1:0] mem_radrs_ld;
  logic [31:0]   instruction_fetch;
  logic [31:0]   mem_store_data;
  logic          fetch_enabled;
  logic [AW-1:0] pc_cnt;
  logic [AW:0]   load_count;

  int tests  = 0;
  int failed = 0;

  logic [31:0] a_words [4] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222, 32'hA333_3333};

  cpu_mem_ctrl #(.AW(AW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .halt_req          (halt_req),
    .prog_valid        (prog_valid),
    .prog_data         (prog_data),
    .prog_last         (prog_last),
    .prog_ready        (prog_ready),
    .branch_valid      (branch_valid),
    .branch_address    (branch_address),
    .write_mem         (write_mem),
    .mem_wadrs         (mem_wadrs),
    .mem_wdata         (mem_wdata),
    .read_mem_str      (read_mem_str),
    .mem_radrs_ld      (mem_radrs_ld),
    .instruction_fetch (instruction_fetch),
    .mem_store_data    (mem_store_data),
    .fetch_enabled     (fetch_enabled),
    .pc_cnt            (pc_cnt),
    .load_count        (load_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; halt_req = 1'b0;
    prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    branch_valid = 1'b0; branch_address = '0;
    write_mem = 1'b0; mem_wadrs = '0; mem_wdata = '0;
    read_mem_str = 1'b0; mem_radrs_ld = '0;
    tick(); tick();

    check("rst_prog_ready", prog_ready, 0);
    check("rst_fetch_en", fetch_enabled, 0);
    check("rst_pc", pc_cnt, 0);
    check("rst_load_count", load_count, 0);
    check("rst_store_data", mem_store_data, 0);
    check("rst_ifetch", instruction_fetch, 0);

    // Basic load of four words, then sequential fetch
    resetn = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("load_prog_ready", prog_ready, 1);
    check("load_fetch_en", fetch_enabled, 0);
    for (int i = 0; i < 4; i++) send_word(a_words[i], i == 3);
    check("load_count_4", load_count, 4);
    check("run_prog_ready", prog_ready, 0);
    check("run_fetch_en", fetch_enabled, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq_pc_%0d", k), pc_cnt, k);
      check($sformatf("seq_if_%0d", k), instruction_fetch, a_words[k]);
      tick();
    end
    tick();
    check("pc_5", pc_cnt, 5);

    // Branch
    branch_valid = 1'b1; branch_address = 11'h040;
    tick();
    branch_valid = 1'b0;
    check("branch_pc", pc_cnt, 11'h040);
    tick();
    check("branch_pc_inc", pc_cnt, 11'h041);

    // Store then load, then same-cycle write-first
    write_mem = 1'b1; mem_wadrs = 11'h100; mem_wdata = 32'hDEAD_BEEF;
    tick();
    write_mem = 1'b0;
    read_mem_str = 1'b1; mem_radrs_ld = 11'h100;
    tick();
    read_mem_str = 1'b0;
    check("load_deadbeef", mem_store_data, 32'hDEAD_BEEF);
    write_mem = 1'b1; mem_wadrs = 11'h101; mem_wdata = 32'h1234_5678;
    read_mem_str = 1'b1; mem_radrs_ld = 11'h101;
    tick();
    write_mem = 1'b0; read_mem_str = 1'b0;
    check("write_first", mem_store_data, 32'h1234_5678);
    mem_radrs_ld = 11'h100;
    tick();
    check("load_hold", mem_store_data, 32'h1234_5678);

    // Store to the fetch address lands on instruction_fetch next cycle
    branch_valid = 1'b1; branch_address = 11'h200;
    write_mem = 1'b1; mem_wadrs = 11'h200; mem_wdata = 32'hCAFE_0001;
    tick();
    branch_valid = 1'b0; write_mem = 1'b0;
    check("store_fetch_pc", pc_cnt, 11'h200);
    check("store_fetch_if", instruction_fetch, 32'hCAFE_0001);

    // Halt has priority over branch
    branch_valid = 1'b1; branch_address = 11'h007;
    tick();
    branch_valid = 1'b0;
    check("pc_7", pc_cnt, 7);
    halt_req = 1'b1; branch_valid = 1'b1; branch_address = 11'h040;
    tick();
    halt_req = 1'b0; branch_valid = 1'b0;
    check("halt_pc", pc_cnt, 7);
    check("halt_fetch_en", fetch_enabled, 0);
    check("halt_ifetch", instruction_fetch, 0);
    branch_valid = 1'b1; branch_address = 11'h003;
    read_mem_str = 1'b1; mem_radrs_ld = 11'h100;
    tick();
    branch_valid = 1'b0; read_mem_str = 1'b0;
    check("halt_stays_pc", pc_cnt, 7);
    check("halt_stays_fen", fetch_enabled, 0);
    check("halt_load", mem_store_data, 32'hDEAD_BEEF);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("halt_to_load_ready", prog_ready, 1);
    check("halt_to_load_cnt", load_count, 0);

    // Reset partway through a load
    send_word(32'hB000_0000, 1'b0);
    send_word(32'hB111_1111, 1'b0);
    check("partial_count", load_count, 2);
    resetn = 1'b0; prog_valid = 1'b1; prog_data = 32'h0BAD_0BAD;
    tick();
    resetn = 1'b1; prog_valid = 1'b0;
    check("midrst_ready", prog_ready, 0);
    check("midrst_count", load_count, 0);
    check("midrst_fen", fetch_enabled, 0);
    check("midrst_pc", pc_cnt, 0);
    // Store in IDLE must be dropped
    write_mem = 1'b1; mem_wadrs = 11'h001; mem_wdata = 32'hFFFF_FFFF;
    tick();
    write_mem = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'hC000_0000, 1'b1);
    check("reload_count", load_count, 1);
    check("reload_if0", instruction_fetch, 32'hC000_0000);
    tick();
    check("kept_word1", instruction_fetch, 32'hB111_1111);
    tick();
    check("no_write_in_rst", instruction_fetch, a_words[2]);

    // Fill the whole memory without prog_last, then wrap the PC
    resetn = 1'b0;
    tick();
    resetn = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("full_ready_before_last", prog_ready, 1);
      send_word(32'h5A00_0000 ^ 32'(i), 1'b0);
    end
    check("full_count", load_count, DEPTH);
    check("full_fen", fetch_enabled, 1);
    check("full_pc0", pc_cnt, 0);
    check("full_if0", instruction_fetch, 32'h5A00_0000);
    for (int i = 0; i < DEPTH; i++) tick();
    check("wrap_pc0", pc_cnt, 0);
    tick();
    check("wrap_pc1", pc_cnt, 1);
    check("wrap_if1", instruction_fetch, 32'h5A00_0001);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
